multicore_out_collector: RTL and testbench
==========================================

# multicore_out_collector

Output-side companion to the multicore array of `rede_float` cores. Each core signals a result with a one-cycle, non-zero 4-bit `out_en` tag alongside its 28-bit `io_out`. This block captures every such event without loss, arbitrates fairly between cores, and drains results through a FIFO to a single valid/ready stream. It replaces lossy fixed-priority muxing when several cores finish in the same or nearby cycles.

## Interface
Parameters:
- `NCORES`, 22, number of cores served (1..32).
- `DW`, 28, result width (signed, two's complement, passed through unmodified).
- `FIFO_DEPTH`, 8, output FIFO entries (power of two, ≥2).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `io_out_bus`  in  DW*NCORES  core i result in bits [DW*i+DW-1 : DW*i].
- `out_en_bus`  in  4*NCORES  core i tag in bits [4*i+3 : 4*i]; non-zero = event this cycle.
- `m_data`  out  DW  result word.
- `m_core`  out  5  originating core index.
- `m_tag`  out  4  `out_en` tag captured with the result.
- `m_valid`  out  1  FIFO head valid.
- `m_ready`  in  1  consumer accepts head when `m_valid & m_ready`.
- `overrun`  out  NCORES  sticky per-core lost-event flag.
- `drop_cnt`  out  16  saturating count of lost events.
- `overrun_clr`  in  1  synchronous pulse: clear `overrun` and `drop_cnt`.

## Operation
- Per-core holding stage: `hold_data[i]`, `hold_tag[i]`, `pend[i]`.
- Capture: on a clock edge with `out_en_bus[i] != 0`:
  - If `pend[i]` is 0, or core i is granted that same cycle, load data/tag and set `pend[i]`.
  - Otherwise, drop the event: set `overrun[i]` and increment `drop_cnt`, saturating at 0xFFFF. The held value is kept.
- Arbiter: round-robin over `pend`. Search starts at `rr_ptr` (reset 0). Grant the first pending core at index ≥ `rr_ptr`, wrapping modulo NCORES. On grant, `rr_ptr` becomes grant+1, with wrap NCORES-1 → 0.
- A grant occurs only when the FIFO is not full, or is full and popping that cycle. A granted entry is pushed as {core, tag, data} and `pend` is cleared, unless it is reloaded in the same cycle per the capture rule.
- At most one grant per cycle. A simultaneous push and pop leaves the FIFO occupancy unchanged.
- FIFO is first-word-fall-through. Outputs are driven from the registered head. `m_data`, `m_core` and `m_tag` are held stable while `m_valid & !m_ready`.
- `overrun_clr` has priority over a same-cycle drop: the result is cleared, and that drop is not counted.

## Timing
- Reset: the following are 0 asynchronously on `rst`=0, and stay 0 until the first edge after release:
  - `m_valid`, `m_data`, `m_core`, `m_tag`, `overrun`, `drop_cnt`
  - all `pend` flags, `rr_ptr`, FIFO pointers.
- Reset mid-operation discards all held and queued results.
- Latency with idle FIFO and no contention:
  - Event in cycle t → `pend` set after edge t.
  - Grant in t+1 → `m_valid`=1 in cycle t+2.
- Throughput: one result per cycle sustained.
- Contention: k simultaneous events emerge in round-robin order over k consecutive cycles, provided `m_ready`=1.
- FIFO full with `m_ready`=0: grants stall and `pend` holds. Events are dropped only on a second event to an already-pending core.
- Full FIFO with a pop in the same cycle allows a grant in that cycle.

## Test plan
- Core 5 tag 1 data 0x0ABCDEF at t0, `m_ready`=1 → `m_valid`=1 at t0+2 for exactly one cycle; `m_core`=5, `m_tag`=1, `m_data`=0x0ABCDEF.
- Cores 0, 3, 21 with tags 1, 2, 3 in the same cycle after reset → outputs in order core 0, 3, 21 on three consecutive cycles; no drops.
- Round-robin: grant core 3, then cores 1 and 4 pend together → core 4 output before core 1; `rr_ptr` wraps correctly past core 21 to 0.
- Back-pressure: `m_ready`=0, one event each on cores 0..8 → FIFO holds 8 entries, `pend[8]`=1. A second event on core 8 → `overrun[8]`=1, `drop_cnt`=1. Then `m_ready`=1 → 9 words (cores 0..8, original core-8 data) on consecutive cycles.
- Data integrity: core 12 data -1 (0xFFFFFFF), tag 0xF → `m_data`=0xFFFFFFF, `m_tag`=0xF. `overrun_clr` pulse → `overrun`=0, `drop_cnt`=0.
- Async reset with 3 queued words and 2 pending → `m_valid`=0 immediately without a clock edge. After release, no stale outputs appear; the next event has latency 2.

Source files
------------

// File: rtl/multicore_out_collector.sv
// rtl/multicore_out_collector.sv - lossless result collector for a multicore array
//
// Purpose:
//   Captures one-cycle result events from NCORES cores into per-core holding
//   registers, arbitrates round-robin among pending cores, and drains the
//   granted results through a first-word-fall-through FIFO to a single
//   valid/ready stream. A second event to a core whose previous result is
//   still pending is counted as lost.
//
// Ports:
//   clk          clock, all state on rising edge
//   rst          asynchronous active-low reset
//   io_out_bus   core i result in bits [DW*i +: DW]
//   out_en_bus   core i tag in bits [4*i +: 4]; non-zero marks an event
//   m_data       head result word
//   m_core       head originating core index
//   m_tag        head captured tag
//   m_valid      FIFO head valid
//   m_ready      consumer accepts head when m_valid & m_ready
//   overrun      sticky per-core lost-event flags
//   drop_cnt     saturating count of lost events
//   overrun_clr  synchronous pulse clearing overrun and drop_cnt

module multicore_out_collector #(
  parameter int NCORES     = 22,
  parameter int DW         = 28,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW*NCORES-1:0] io_out_bus,
  input  logic [4*NCORES-1:0]  out_en_bus,
  output logic [DW-1:0]        m_data,
  output logic [4:0]           m_core,
  output logic [3:0]           m_tag,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [NCORES-1:0]    overrun,
  output logic [15:0]          drop_cnt,
  input  logic                 overrun_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // Per-core holding stage
  logic [DW-1:0]     hold_data [NCORES];
  logic [3:0]        hold_tag  [NCORES];
  logic [NCORES-1:0] pend;

  // Round-robin arbiter state
  logic [4:0]        rr_ptr;

  // Output FIFO storage and pointers
  logic [DW-1:0]     fifo_data [FIFO_DEPTH];
  logic [4:0]        fifo_core [FIFO_DEPTH];
  logic [3:0]        fifo_tag  [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  // Combinational control
  logic [NCORES-1:0] ev;
  logic [NCORES-1:0] gnt_vec;
  logic [NCORES-1:0] drop;
  logic              gnt_found;
  logic [4:0]        gnt_idx;
  logic              grant;
  logic              pop;
  logic              full;
  logic [5:0]        ndrop;
  logic [16:0]       drop_sum;
  int                scan_idx;

  // Event detect: any non-zero tag is an event this cycle.
  always_comb begin
    ev = '0;
    for (int i = 0; i < NCORES; i++) begin
      ev[i] = |out_en_bus[4*i +: 4];
    end
  end

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign m_valid = (count != '0);
  assign pop     = m_valid & m_ready;

  // Head is read straight out of the storage registers (FWFT); it only moves
  // when rd_ptr advances, so it is stable while the consumer stalls.
  assign m_data  = fifo_data[rd_ptr];
  assign m_core  = fifo_core[rd_ptr];
  assign m_tag   = fifo_tag[rd_ptr];

  // Round-robin search: first pending core at or after rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    for (int off = 0; off < NCORES; off++) begin
      scan_idx = int'(rr_ptr) + off;
      if (scan_idx >= NCORES) begin
        scan_idx = scan_idx - NCORES;
      end
      if (!gnt_found && pend[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx[4:0];
      end
    end
  end

  // A full FIFO can still accept a push when the head leaves the same cycle.
  assign grant = gnt_found & (~full | pop);

  always_comb begin
    gnt_vec = '0;
    if (grant) begin
      gnt_vec[gnt_idx] = 1'b1;
    end
  end

  // An event is lost only when the core already holds an unsent result that
  // is not leaving this cycle.
  assign drop = ev & pend & ~gnt_vec;

  // Several cores may lose an event in the same cycle.
  always_comb begin
    ndrop = '0;
    for (int i = 0; i < NCORES; i++) begin
      ndrop = ndrop + 6'(drop[i]);
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + 17'(ndrop);

  // Holding stage and pending flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend <= '0;
      for (int i = 0; i < NCORES; i++) begin
        hold_data[i] <= '0;
        hold_tag[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NCORES; i++) begin
        if (ev[i] && (!pend[i] || gnt_vec[i])) begin
          hold_data[i] <= io_out_bus[DW*i +: DW];
          hold_tag[i]  <= out_en_bus[4*i +: 4];
          pend[i]      <= 1'b1;
        end else if (gnt_vec[i]) begin
          pend[i]      <= 1'b0;
        end
      end
    end
  end

  // Arbiter pointer: next search starts just past the last grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (grant) begin
      if (gnt_idx == 5'(NCORES-1)) begin
        rr_ptr <= '0;
      end else begin
        rr_ptr <= gnt_idx + 5'd1;
      end
    end
  end

  // FIFO write/read. Pointers wrap naturally since depth is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        fifo_data[j] <= '0;
        fifo_core[j] <= '0;
        fifo_tag[j]  <= '0;
      end
    end else begin
      if (grant) begin
        fifo_data[wr_ptr] <= hold_data[gnt_idx];
        fifo_core[wr_ptr] <= gnt_idx;
        fifo_tag[wr_ptr]  <= hold_tag[gnt_idx];
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({grant, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Loss reporting; a clear wins over drops in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun  <= '0;
      drop_cnt <= '0;
    end else if (overrun_clr) begin
      overrun  <= '0;
      drop_cnt <= '0;
    end else begin
      overrun <= overrun | drop;
      if (drop_sum[16]) begin
        drop_cnt <= 16'hFFFF;
      end else begin
        drop_cnt <= drop_sum[15:0];
      end
    end
  end

endmodule

// File: tb/tb_multicore_out_collector.sv
// tb/tb_multicore_out_collector.sv - self-checking bench for multicore_out_collector

module tb_multicore_out_collector;

  localparam int NC = 22;
  localparam int DW = 28;
  localparam int FD = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DW*NC-1:0]  io_out_bus = '0;
  logic [4*NC-1:0]   out_en_bus = '0;
  logic [DW-1:0]     m_data;
  logic [4:0]        m_core;
  logic [3:0]        m_tag;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [NC-1:0]     overrun;
  logic [15:0]       drop_cnt;
  logic              overrun_clr = 1'b0;

  multicore_out_collector #(.NCORES(NC), .DW(DW), .FIFO_DEPTH(FD)) dut (
    .clk         (clk),
    .rst         (rst),
    .io_out_bus  (io_out_bus),
    .out_en_bus  (out_en_bus),
    .m_data      (m_data),
    .m_core      (m_core),
    .m_tag       (m_tag),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .overrun     (overrun),
    .drop_cnt    (drop_cnt),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              core;
    logic [3:0]      tag;
    logic [DW-1:0]   data;
    logic [4:0]      exp_core;
    logic [3:0]      exp_tag;
    logic [DW-1:0]   exp_data;
  } vec_t;

  typedef struct {
    logic [4:0]    core;
    logic [3:0]    tag;
    logic [DW-1:0] data;
  } exp_t;

  vec_t  vecs [4];
  exp_t  exp_q [$];
  exp_t  mon_e;
  int    n_checks = 0;
  int    n_pass   = 0;
  logic [DW-1:0] saved_data;
  logic [4:0]    saved_core;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  task automatic set_event(input int c, input logic [3:0] tag, input logic [DW-1:0] data);
    out_en_bus[4*c +: 4]   = tag;
    io_out_bus[DW*c +: DW] = data;
  endtask

  task automatic push_exp(input int c, input logic [3:0] tag, input logic [DW-1:0] data);
    exp_t e;
    e.core = 5'(c);
    e.tag  = tag;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Scramble the data bus so a result is only correct if it was captured.
  task automatic clear_bus();
    out_en_bus = '0;
    for (int w = 0; w < NC; w++) io_out_bus[DW*w +: DW] = DW'($urandom);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (2) nedge();
    rst = 1'b1;
  endtask

  // Single event into an idle collector: visible for exactly one cycle at t+2.
  task automatic single_event(input int c, input logic [3:0] tag, input logic [DW-1:0] data,
                              input logic [4:0] ec, input logic [3:0] et, input logic [DW-1:0] ed);
    tick();
    set_event(c, tag, data);
    push_exp(int'(ec), et, ed);
    tick();
    clear_bus();
    nedge(); check("lat_t1_valid", m_valid, 0);
    nedge(); check("lat_t2_valid", m_valid, 1);
    nedge(); check("lat_t3_valid", m_valid, 0);
  endtask

  // Scoreboard: every accepted head word must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got core %0d data 0x%0h, expected none", m_core, m_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_core", m_core, mon_e.core);
        check("out_tag",  m_tag,  mon_e.tag);
        check("out_data", m_data, mon_e.data);
      end
    end
  end

  initial begin
    vecs[0] = '{5,  4'h1, 28'h0ABCDEF, 5'd5,  4'h1, 28'h0ABCDEF};
    vecs[1] = '{12, 4'hF, 28'hFFFFFFF, 5'd12, 4'hF, 28'hFFFFFFF};
    vecs[2] = '{21, 4'h8, 28'h8000000, 5'd21, 4'h8, 28'h8000000};
    vecs[3] = '{0,  4'h2, 28'h0000001, 5'd0,  4'h2, 28'h0000001};

    // Reset state
    #2;
    check("rst_m_valid",  m_valid,  0);
    check("rst_m_data",   m_data,   0);
    check("rst_m_core",   m_core,   0);
    check("rst_m_tag",    m_tag,    0);
    check("rst_overrun",  overrun,  0);
    check("rst_drop_cnt", drop_cnt, 0);
    repeat (2) nedge();
    rst = 1'b1;

    // Simultaneous events on cores 0, 3, 21 straight after reset
    tick();
    set_event(0, 4'h1, 28'h1000000); push_exp(0, 4'h1, 28'h1000000);
    set_event(3, 4'h2, 28'h2000003); push_exp(3, 4'h2, 28'h2000003);
    set_event(21, 4'h3, 28'h3000021); push_exp(21, 4'h3, 28'h3000021);
    tick();
    clear_bus();
    nedge(); check("multi_t1_valid", m_valid, 0);
    nedge(); check("multi_t2_valid", m_valid, 1);
    nedge(); check("multi_t3_valid", m_valid, 1);
    nedge(); check("multi_t4_valid", m_valid, 1);
    nedge(); check("multi_t5_valid", m_valid, 0);
    check("multi_drop_cnt", drop_cnt, 0);
    check("multi_overrun",  overrun,  0);

    // Table of single-event vectors
    for (int v = 0; v < 4; v++) begin
      single_event(vecs[v].core, vecs[v].tag, vecs[v].data,
                   vecs[v].exp_core, vecs[v].exp_tag, vecs[v].exp_data);
    end

    // Round-robin ordering and wrap past the last core
    apply_reset();
    single_event(3, 4'h4, 28'h0333333, 5'd3, 4'h4, 28'h0333333);
    tick();
    set_event(1, 4'h5, 28'h0111111);
    set_event(4, 4'h6, 28'h0444444);
    push_exp(4, 4'h6, 28'h0444444);
    push_exp(1, 4'h5, 28'h0111111);
    tick();
    clear_bus();
    repeat (5) nedge();
    tick();
    set_event(0, 4'h7, 28'h0A00000);
    set_event(21, 4'h8, 28'h0A00021);
    push_exp(21, 4'h8, 28'h0A00021);
    push_exp(0, 4'h7, 28'h0A00000);
    tick();
    clear_bus();
    repeat (5) nedge();
    check("rr_queue_drained", 64'(exp_q.size()), 0);

    // Back-pressure, overrun, and clear priority over a same-cycle drop
    apply_reset();
    m_ready = 1'b0;
    tick();
    for (int c = 0; c <= 8; c++) begin
      set_event(c, 4'(c + 1), 28'(c * 32'h1111 + 7));
      push_exp(c, 4'(c + 1), 28'(c * 32'h1111 + 7));
    end
    tick();
    clear_bus();
    repeat (12) nedge();
    check("bp_valid",     m_valid,  1);
    check("bp_head_core", m_core,   0);
    check("bp_overrun0",  overrun,  0);
    check("bp_drop0",     drop_cnt, 0);
    saved_data = m_data;
    saved_core = m_core;
    nedge();
    check("bp_hold_data", m_data, saved_data);
    check("bp_hold_core", m_core, saved_core);
    tick();
    set_event(8, 4'h9, 28'h5555555);
    tick();
    clear_bus();
    nedge();
    check("bp_overrun8", overrun,  64'(22'h000100));
    check("bp_drop1",    drop_cnt, 1);
    tick();
    set_event(8, 4'hA, 28'h6666666);
    overrun_clr = 1'b1;
    tick();
    clear_bus();
    overrun_clr = 1'b0;
    nedge();
    check("clr_overrun",  overrun,  0);
    check("clr_drop_cnt", drop_cnt, 0);
    tick();
    m_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      nedge();
      check("bp_drain_valid", m_valid, 1);
    end
    nedge();
    check("bp_drain_end", m_valid, 0);

    // Asynchronous reset with queued and pending results
    m_ready = 1'b0;
    tick();
    for (int c = 0; c <= 4; c++) set_event(c, 4'hC, 28'(32'h0C00000 + c));
    tick();
    clear_bus();
    repeat (3) tick();
    check("pre_reset_valid", m_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_valid", m_valid,  0);
    check("async_rst_data",  m_data,   0);
    check("async_rst_core",  m_core,   0);
    check("async_rst_tag",   m_tag,    0);
    exp_q.delete();
    m_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      nedge();
      check("post_rst_no_stale", m_valid, 0);
    end
    single_event(7, 4'h3, 28'h0777777, 5'd7, 4'h3, 28'h0777777);

    // Bounded drain of anything still expected
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) nedge();
    check("final_queue_empty", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
